lvds_rx_word_align: RTL and testbench

- Downstream of the RX PLL; runs in the PLL C0 (pixel/word) clock domain.
- Consumes the PLL lock and the 7-bit deserialized LVDS clock-lane word.
- Issues bitslip pulses to the deserializer until the clock-lane word matches the 7:1 framing pattern, then asserts aligned and releases the data-path reset.
- Requests a PLL reset when alignment cannot be reached, and re-aligns after lock loss or persistent pattern errors.

---
 rtl/lvds_rx_word_align.sv | 182 ++++++++++++++++++
 tb/tb_lvds_rx_word_align.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_word_align.sv
// rtl/lvds_rx_word_align.sv - LVDS clock-lane word aligner driving deserializer bitslip
module lvds_rx_word_align #(
    parameter logic [6:0] PATTERN       = 7'b1100011,
    parameter int         SETTLE_CYCLES = 256,
    parameter int         SLIP_WAIT     = 4,
    parameter int         MATCH_COUNT   = 16,
    parameter int         ERR_LIMIT     = 4,
    parameter int         MAX_SLIPS     = 14,
    parameter int         RST_PULSE     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic [6:0] clk_lane_data,
    output logic       bitslip,
    output logic       aligned,
    output logic       data_rst,
    output logic       pllreset_req,
    output logic [3:0] slip_cnt
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SWT_W = $clog2(SLIP_WAIT + 1);
    localparam int MAT_W = $clog2(MATCH_COUNT + 1);
    localparam int ERR_W = $clog2(ERR_LIMIT + 1);
    localparam int RST_W = $clog2(RST_PULSE + 1);

    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SWT_W-1:0] SWT_LAST  = SWT_W'(SLIP_WAIT - 1);
    localparam logic [MAT_W-1:0] MAT_LAST  = MAT_W'(MATCH_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(ERR_LIMIT - 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_PULSE - 1);
    localparam logic [3:0]       SLIP_MAX  = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_SLIP_WAIT,
        ST_ALIGNED,
        ST_PLL_RST
    } state_t;

    state_t             state_q, state_d;
    logic               lock_meta_q, lock_s_q;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [SWT_W-1:0]   swait_q, swait_d;
    logic [MAT_W-1:0]   match_q, match_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [RST_W-1:0]   pulse_q, pulse_d;
    logic [3:0]         slip_q, slip_d;
    logic               aligned_q, aligned_d;
    logic               word_ok;

    assign word_ok = (clk_lane_data == PATTERN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= ST_WAIT_LOCK;
            settle_q    <= '0;
            swait_q     <= '0;
            match_q     <= '0;
            err_q       <= '0;
            pulse_q     <= '0;
            slip_q      <= '0;
            aligned_q   <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            settle_q    <= settle_d;
            swait_q     <= swait_d;
            match_q     <= match_d;
            err_q       <= err_d;
            pulse_q     <= pulse_d;
            slip_q      <= slip_d;
            aligned_q   <= aligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        swait_d      = swait_q;
        match_d      = match_q;
        err_d        = err_q;
        pulse_d      = pulse_q;
        slip_d       = slip_q;
        bitslip      = 1'b0;
        pllreset_req = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                settle_d = '0;
                swait_d  = '0;
                match_d  = '0;
                err_d    = '0;
                pulse_d  = '0;
                slip_d   = '0;
                if (lock_s_q) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    settle_d = '0;
                    state_d  = ST_CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (word_ok) begin
                    match_d = match_q + 1'b1;
                    if (match_q == MAT_LAST) begin
                        err_d   = '0;
                        state_d = ST_ALIGNED;
                    end
                end else begin
                    match_d = '0;
                    state_d = (slip_q == SLIP_MAX) ? ST_PLL_RST : ST_SLIP;
                end
            end
            ST_SLIP: begin
                bitslip = 1'b1;
                if (slip_q != 4'hF) slip_d = slip_q + 4'd1;
                swait_d = '0;
                state_d = ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
                if (swait_q == SWT_LAST) begin
                    swait_d = '0;
                    state_d = ST_CHECK;
                end else begin
                    swait_d = swait_q + 1'b1;
                end
            end
            ST_ALIGNED: begin
                if (word_ok) begin
                    err_d = '0;
                end else if (err_q == ERR_LAST) begin
                    err_d   = '0;
                    match_d = '0;
                    slip_d  = '0;
                    state_d = ST_CHECK;
                end else begin
                    err_d = err_q + 1'b1;
                end
            end
            ST_PLL_RST: begin
                pllreset_req = 1'b1;
                if (pulse_q == RST_LAST) begin
                    pulse_d = '0;
                    slip_d  = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Lock loss overrides everything decided above, including a pending slip
        if (!lock_s_q && state_q != ST_WAIT_LOCK && state_q != ST_PLL_RST) begin
            state_d  = ST_WAIT_LOCK;
            bitslip  = 1'b0;
            settle_d = '0;
            swait_d  = '0;
            match_d  = '0;
            err_d    = '0;
            pulse_d  = '0;
            slip_d   = '0;
        end

        aligned_d = (state_d == ST_ALIGNED);
    end

    assign aligned  = aligned_q;
    assign data_rst = ~aligned_q;
    assign slip_cnt = slip_q;

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// tb/tb_lvds_rx_word_align.sv - self-checking bench for lvds_rx_word_align
module tb_lvds_rx_word_align;
    localparam logic [6:0] PAT = 7'b1100011;
    localparam int SETTLE = 256;
    localparam int SWAIT  = 4;
    localparam int MCNT   = 16;
    localparam int ELIM   = 4;
    localparam int MSLIP  = 14;
    localparam int RPULSE = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic [6:0] clk_lane_data = 7'd0;
    logic       bitslip, aligned, data_rst, pllreset_req;
    logic [3:0] slip_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int nslips = 0;
    int last_slip = -100;
    int gap_bad = 0;
    int rot = 0;
    bit use_rot = 1'b0;

    typedef struct {
        int rot;
        int exp_slips;
    } vec_t;
    vec_t vecs[4];

    lvds_rx_word_align dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .clk_lane_data(clk_lane_data),
        .bitslip      (bitslip),
        .aligned      (aligned),
        .data_rst     (data_rst),
        .pllreset_req (pllreset_req),
        .slip_cnt     (slip_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] rotl(input logic [6:0] w, input int n);
        logic [6:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
        return r;
    endfunction

    function automatic logic [6:0] bad_word();
        logic [6:0] w;
        w = 7'($urandom_range(0, 127));
        if (w == PAT) w = w ^ 7'd1;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Deserializer model: every observed bitslip pulse rotates the word left by one
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bitslip === 1'b1) begin
            if (cyc - last_slip < SWAIT + 2) gap_bad++;
            last_slip = cyc;
            nslips++;
            if (use_rot) rot = (rot + 1) % 7;
        end
        if (use_rot) clk_lane_data = rotl(PAT, rot);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_bitslip", bitslip, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_data_rst", data_rst, 1);
        chk("rst_pllreset_req", pllreset_req, 0);
        chk("rst_slip_cnt", slip_cnt, 0);
        tick();
        rst = 1'b0;
        last_slip = -100;
    endtask

    task automatic align_run(input string tag, input int t0, input int exp_slips);
        int exp_lat;
        pll_lock = 1'b1;
        nslips = 0;
        gap_bad = 0;
        exp_lat = 2 + 1 + SETTLE + exp_slips * (2 + SWAIT) + MCNT;
        while (aligned !== 1'b1 && pllreset_req !== 1'b1 && cyc - t0 < 3000) tick();
        chk({tag, "_latency"}, cyc - t0, exp_lat);
        chk({tag, "_slips"}, nslips, exp_slips);
        chk({tag, "_slip_cnt"}, slip_cnt, exp_slips);
        chk({tag, "_data_rst"}, data_rst, 0);
        chk({tag, "_gap"}, gap_bad, 0);
    endtask

    initial begin
        logic [6:0] seq[$];
        int run;
        bit lost;
        int t0;
        int cnt;
        int strays;

        vecs[0] = '{rot: 0, exp_slips: 0};
        vecs[1] = '{rot: 4, exp_slips: 3};
        vecs[2] = '{rot: 6, exp_slips: 1};
        vecs[3] = '{rot: 1, exp_slips: 6};

        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("idle_aligned", aligned, 0);
        chk("idle_slip_cnt", slip_cnt, 0);

        for (int v = 0; v < 4; v++) begin
            pll_lock = 1'b0;
            use_rot = 1'b1;
            rot = vecs[v].rot;
            clk_lane_data = rotl(PAT, rot);
            do_reset();
            align_run($sformatf("vec%0d", v), cyc, vecs[v].exp_slips);
        end

        for (int r = 0; r < 3; r++) begin
            pll_lock = 1'b0;
            use_rot = 1'b1;
            rot = $urandom_range(0, 6);
            clk_lane_data = rotl(PAT, rot);
            do_reset();
            align_run($sformatf("rnd%0d", r), cyc, (7 - rot) % 7);
        end

        // Error tolerance: fixed 3-1-3 prefix, random tail, forced run of ELIM bad words
        use_rot = 1'b0;
        seq = {};
        for (int i = 0; i < 3; i++) seq.push_back(bad_word());
        seq.push_back(PAT);
        for (int i = 0; i < 3; i++) seq.push_back(bad_word());
        seq.push_back(PAT);
        seq.push_back(PAT);
        for (int i = 0; i < 20; i++) seq.push_back(($urandom_range(0, 1) == 0) ? PAT : bad_word());
        for (int i = 0; i < ELIM; i++) seq.push_back(bad_word());
        run = 0;
        lost = 1'b0;
        for (int i = 0; i < seq.size() && !lost; i++) begin
            clk_lane_data = seq[i];
            tick();
            if (seq[i] == PAT) run = 0;
            else run++;
            if (run >= ELIM) lost = 1'b1;
            chk($sformatf("errtol_aligned_w%0d", i), aligned, lost ? 0 : 1);
        end
        nslips = 0;
        clk_lane_data = PAT;
        for (int i = 1; i <= MCNT; i++) begin
            tick();
            chk($sformatf("realign_c%0d", i), aligned, (i == MCNT) ? 1 : 0);
        end
        chk("realign_slip_cnt", slip_cnt, 0);
        chk("realign_no_slips", nslips, 0);

        // Lock loss for one cycle while aligned
        use_rot = 1'b1;
        rot = 0;
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        t0 = cyc;
        chk("lockloss_c1_aligned", aligned, 1);
        tick();
        chk("lockloss_c2_aligned", aligned, 1);
        tick();
        chk("lockloss_c3_aligned", aligned, 0);
        chk("lockloss_c3_data_rst", data_rst, 1);
        align_run("relock", t0, 0);

        // Alignment never reached
        pll_lock = 1'b0;
        use_rot = 1'b0;
        clk_lane_data = 7'd0;
        do_reset();
        t0 = cyc;
        pll_lock = 1'b1;
        nslips = 0;
        gap_bad = 0;
        while (pllreset_req !== 1'b1 && cyc - t0 < 3000) tick();
        chk("noalign_pllreset_time", cyc - t0, 2 + 1 + SETTLE + MSLIP * (2 + SWAIT) + 1);
        chk("noalign_slips", nslips, MSLIP);
        chk("noalign_slip_cnt", slip_cnt, MSLIP);
        chk("noalign_gap", gap_bad, 0);
        chk("noalign_aligned", aligned, 0);
        pll_lock = 1'b0;
        cnt = 0;
        while (pllreset_req === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("pllreset_width", cnt, RPULSE);
        chk("after_pllrst_slip_cnt", slip_cnt, 0);
        strays = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bitslip !== 1'b0 || pllreset_req !== 1'b0 || aligned !== 1'b0) strays++;
        end
        chk("after_pllrst_idle", strays, 0);

        // Async reset while waiting after the fifth slip
        use_rot = 1'b1;
        rot = 1;
        clk_lane_data = rotl(PAT, rot);
        do_reset();
        pll_lock = 1'b1;
        nslips = 0;
        t0 = cyc;
        while (nslips < 5 && cyc - t0 < 3000) tick();
        tick();
        chk("midslip_slip_cnt", slip_cnt, 5);
        chk("midslip_bitslip", bitslip, 0);
        do_reset();
        align_run("post_rst", cyc, (7 - rot) % 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
